sparc_ifu_thrwait: RTL and testbench

- Parametrised thread wait/completion tracker for the IFU.
- Holds a per-thread bitmask of outstanding wait conditions, e.g. imiss, long-latency op, store-buffer wait.
- Each condition has a set and a clear vector. A unified completion pulse is generated when a waiting thread's last pending condition clears.
- Adds a per-thread stall watchdog with sticky timeout flags, and an optional registered completion output. Sits between the per-unit done signals and the thread switch logic.

---
 rtl/sparc_ifu_thrwait_pkg.sv | 18 +
 rtl/sparc_ifu_thrwait_slice.sv | 61 ++++++
 rtl/sparc_ifu_thrwait.sv | 83 ++++++++
 tb/tb_sparc_ifu_thrwait.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sparc_ifu_thrwait_pkg.sv
// Shared constants and indexing helper for the IFU thread wait/completion tracker.
package sparc_ifu_thrwait_pkg;

  localparam int unsigned DEF_NTHR  = 4;
  localparam int unsigned DEF_NCOND = 3;
  localparam int unsigned DEF_TOW   = 10;

  localparam int unsigned WC_IMISS = 0;
  localparam int unsigned WC_OTHER = 1;
  localparam int unsigned WC_STB   = 2;

  // Flat bit position of condition c for thread t in the wait_set/wait_clr/wait_state buses.
  function automatic int unsigned flat_idx(input int unsigned c, input int unsigned t,
                                           input int unsigned nthr);
    return c * nthr + t;
  endfunction

endpackage

// File: rtl/sparc_ifu_thrwait_slice.sv
// One thread's wait tracker: condition mask, raw completion, stall counter and watchdog flag.
module sparc_ifu_thrwait_slice
  import sparc_ifu_thrwait_pkg::*;
#(
  parameter int unsigned NCOND = DEF_NCOND,
  parameter int unsigned TOW   = DEF_TOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [NCOND-1:0] cond_set,
  input  logic [NCOND-1:0] cond_clr,
  input  logic [TOW-1:0]   wd_limit,
  input  logic             wd_ack,
  output logic [NCOND-1:0] cond_state,
  output logic             waiting,
  output logic             raw_cmpl,
  output logic             timeout
);

  localparam logic [TOW-1:0] CntMax = '1;

  logic [NCOND-1:0] state_q, state_d;
  logic [TOW-1:0]   cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             pending;

  always_comb begin
    pending  = |state_q;
    state_d  = {NCOND{active}} & (cond_set | (state_q & ~cond_clr));
    // Completes only when nothing stays pending and nothing new arrives this cycle.
    raw_cmpl = active & pending & ~|(state_q & ~cond_clr) & ~|cond_set;

    cnt_d = cnt_q;
    if (!pending || raw_cmpl) begin
      cnt_d = '0;
    end else if (active && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Equality against the live counter: lowering the limit below the count never fires.
    timeout_d = ((wd_limit != '0) && (cnt_q == wd_limit)) | (timeout_q & ~wd_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign cond_state = state_q;
  assign waiting    = |state_q;
  assign timeout    = timeout_q;

endmodule

// File: rtl/sparc_ifu_thrwait.sv
// IFU thread wait/completion tracker: per-thread slices plus bus (un)flattening and optional
// registered completion.
module sparc_ifu_thrwait
  import sparc_ifu_thrwait_pkg::*;
#(
  parameter int unsigned NTHR     = DEF_NTHR,
  parameter int unsigned NCOND    = DEF_NCOND,
  parameter int unsigned TOW      = DEF_TOW,
  parameter int unsigned CMPL_REG = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  se,
  input  logic [NTHR-1:0]       thr_active,
  input  logic [NTHR*NCOND-1:0] wait_set,
  input  logic [NTHR*NCOND-1:0] wait_clr,
  input  logic [TOW-1:0]        wd_limit,
  input  logic [NTHR-1:0]       wd_ack,
  output logic [NTHR*NCOND-1:0] wait_state,
  output logic [NTHR-1:0]       thr_waiting,
  output logic [NTHR-1:0]       completion,
  output logic [NTHR-1:0]       wd_timeout
);

  logic [NCOND-1:0] slc_set   [NTHR];
  logic [NCOND-1:0] slc_clr   [NTHR];
  logic [NCOND-1:0] slc_state [NTHR];
  logic [NTHR-1:0]  raw_cmpl;

  // Scan enable has no functional effect on this block.
  logic unused_se;
  assign unused_se = se;

  always_comb begin
    wait_state = '0;
    for (int t = 0; t < NTHR; t++) begin
      slc_set[t] = '0;
      slc_clr[t] = '0;
      for (int c = 0; c < NCOND; c++) begin
        slc_set[t][c] = wait_set[flat_idx(c, t, NTHR)];
        slc_clr[t][c] = wait_clr[flat_idx(c, t, NTHR)];
        wait_state[flat_idx(c, t, NTHR)] = slc_state[t][c];
      end
    end
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_ifu_thrwait_slice #(
      .NCOND (NCOND),
      .TOW   (TOW)
    ) u_slice (
      .clk        (clk),
      .reset      (reset),
      .active     (thr_active[t]),
      .cond_set   (slc_set[t]),
      .cond_clr   (slc_clr[t]),
      .wd_limit   (wd_limit),
      .wd_ack     (wd_ack[t]),
      .cond_state (slc_state[t]),
      .waiting    (thr_waiting[t]),
      .raw_cmpl   (raw_cmpl[t]),
      .timeout    (wd_timeout[t])
    );
  end

  if (CMPL_REG != 0) begin : g_cmpl_reg
    logic [NTHR-1:0] cmpl_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cmpl_q <= '0;
      end else begin
        cmpl_q <= raw_cmpl;
      end
    end

    // A reset or deactivation landing in the delay cycle kills the pending pulse.
    assign completion = cmpl_q & thr_active & {NTHR{~reset}};
  end else begin : g_cmpl_comb
    assign completion = raw_cmpl;
  end

endmodule

// File: tb/tb_sparc_ifu_thrwait.sv
// Directed bench for sparc_ifu_thrwait: combinational-completion and registered-completion builds.
module tb_sparc_ifu_thrwait;

  logic        clk = 1'b0;
  logic        reset, se;
  logic [3:0]  thr_active, wd_ack;
  logic [11:0] wait_set, wait_clr;
  logic [9:0]  wd_limit;

  logic [11:0] ws0, ws1;
  logic [3:0]  tw0, tw1, cp0, cp1, to0, to1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sparc_ifu_thrwait #(
    .NTHR(4), .NCOND(3), .TOW(10), .CMPL_REG(0)
  ) dut0 (
    .clk(clk), .reset(reset), .se(se), .thr_active(thr_active),
    .wait_set(wait_set), .wait_clr(wait_clr), .wd_limit(wd_limit), .wd_ack(wd_ack),
    .wait_state(ws0), .thr_waiting(tw0), .completion(cp0), .wd_timeout(to0)
  );

  // Narrow counter so saturation is reachable within a short stall.
  sparc_ifu_thrwait #(
    .NTHR(4), .NCOND(3), .TOW(4), .CMPL_REG(1)
  ) dut1 (
    .clk(clk), .reset(reset), .se(se), .thr_active(thr_active),
    .wait_set(wait_set), .wait_clr(wait_clr), .wd_limit(wd_limit[3:0]), .wd_ack(wd_ack),
    .wait_state(ws1), .thr_waiting(tw1), .completion(cp1), .wd_timeout(to1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] cb(input int c, input int t);
    logic [11:0] m;
    m = '0;
    m[c*4+t] = 1'b1;
    return m;
  endfunction

  task automatic drive(input logic [11:0] s, input logic [11:0] c);
    wait_set = s;
    wait_clr = c;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Thread 2 IMISS set at cycle 0, cleared at cycle 5; optionally drop thread 2 in cycle 6.
  task automatic run_single(input bit drop);
    drive(cb(0, 2), '0); chk("t1_c0_cp0", cp0, 4'b0000); tick();
    for (int k = 1; k <= 4; k++) begin
      drive('0, '0);
      chk("t1_ws0", ws0, 12'h004);
      chk("t1_ws1", ws1, 12'h004);
      chk("t1_tw0", tw0, 4'b0100);
      chk("t1_cp0_idle", cp0, 4'b0000);
      tick();
    end
    drive('0, cb(0, 2));
    chk("t1_c5_cp0", cp0, 4'b0100);
    chk("t1_c5_cp1", cp1, 4'b0000);
    tick();
    if (drop) thr_active = 4'b1011;
    drive('0, '0);
    chk("t1_c6_ws0", ws0, 12'h000);
    chk("t1_c6_ws1", ws1, 12'h000);
    chk("t1_c6_tw0", tw0, 4'b0000);
    chk("t1_c6_cp0", cp0, 4'b0000);
    chk(drop ? "t5_drop_cp1" : "t5_c6_cp1", cp1, drop ? 4'b0000 : 4'b0100);
    tick();
    thr_active = 4'hF;
    drive('0, '0); chk("t1_c7_cp1", cp1, 4'b0000); tick();
  endtask

  initial begin
    reset = 1'b1; se = 1'b0; thr_active = 4'hF; wd_ack = '0;
    wait_set = '0; wait_clr = '0; wd_limit = '0;
    tick(); tick();
    drive('0, '0);
    chk("rst_ws0", ws0, 12'h000);
    chk("rst_to0", to0, 4'b0000);
    chk("rst_cp0", cp0, 4'b0000);
    chk("rst_cp1", cp1, 4'b0000);
    reset = 1'b0;
    tick();

    run_single(1'b0);
    run_single(1'b1);

    // Two conditions on thread 1.
    drive(cb(0, 1) | cb(1, 1), '0); tick();
    for (int k = 1; k <= 2; k++) begin
      drive('0, '0); chk("t2_ws0", ws0, 12'h022); tick();
    end
    drive('0, cb(0, 1)); chk("t2_c3_cp0", cp0, 4'b0000); tick();
    drive('0, '0); chk("t2_c4_ws0", ws0, 12'h020); chk("t2_c4_cp1", cp1, 4'b0000); tick();
    drive('0, '0); tick();
    drive('0, '0); tick();
    drive('0, cb(1, 1)); chk("t2_c7_cp0", cp0, 4'b0010); tick();
    drive('0, '0); chk("t2_c8_ws0", ws0, 12'h000); chk("t2_c8_cp1", cp1, 4'b0010); tick();

    // Set and clear together on thread 0 STB, then clear alone.
    drive(cb(2, 0), '0); tick();
    drive(cb(2, 0), cb(2, 0)); chk("t3_sc_cp0", cp0, 4'b0000); tick();
    drive('0, '0); chk("t3_sc_ws0", ws0, 12'h100); chk("t3_sc_cp1", cp1, 4'b0000); tick();
    drive('0, cb(2, 0)); chk("t3_clr_cp0", cp0, 4'b0001); tick();
    drive('0, '0); chk("t3_clr_ws0", ws0, 12'h000); chk("t3_clr_cp1", cp1, 4'b0001); tick();
    drive('0, 12'hFFF); chk("t3_nop_cp0", cp0, 4'b0000); tick();
    drive('0, '0); chk("t3_nop_ws0", ws0, 12'h000); chk("t3_nop_cp1", cp1, 4'b0000); tick();

    // Deactivating thread 1 while its last condition clears: no completion.
    drive(cb(1, 1), '0); tick();
    thr_active = 4'b1101;
    drive('0, cb(1, 1)); chk("deact_cp0", cp0, 4'b0000); tick();
    thr_active = 4'hF;
    drive('0, '0); chk("deact_ws0", ws0, 12'h000); chk("deact_cp1", cp1, 4'b0000); tick();

    // Watchdog on thread 3, limit 8.
    wd_limit = 10'd8;
    drive(cb(0, 3), '0); tick();
    for (int k = 1; k <= 12; k++) begin
      drive('0, '0);
      chk("wd_rise_to0", to0, (k >= 10) ? 4'b1000 : 4'b0000);
      chk("wd_rise_to1", to1, (k >= 10) ? 4'b1000 : 4'b0000);
      tick();
    end
    wd_ack = 4'b1000;
    drive('0, '0); chk("wd_ack_to0", to0, 4'b1000); tick();
    wd_ack = 4'b0000;
    for (int k = 14; k <= 35; k++) begin
      drive('0, '0);
      chk("wd_norefire_to0", to0, 4'b0000);
      chk("wd_norefire_to1", to1, 4'b0000);
      tick();
    end
    drive('0, cb(0, 3)); chk("wd_cmpl_cp0", cp0, 4'b1000); tick();
    drive('0, '0); chk("wd_cmpl_ws0", ws0, 12'h000); chk("wd_cmpl_cp1", cp1, 4'b1000); tick();

    // Timeouts on threads 0 and 1, thread 1 completes, then reset mid-wait.
    wd_limit = 10'd3;
    drive(cb(0, 0) | cb(0, 1), '0); tick();
    for (int k = 1; k <= 4; k++) begin
      drive('0, '0); chk("t6_pre_to0", to0, 4'b0000); tick();
    end
    drive('0, cb(0, 1));
    chk("t6_to0", to0, 4'b0011);
    chk("t6_to1", to1, 4'b0011);
    chk("t6_cp0", cp0, 4'b0010);
    tick();
    reset = 1'b1;
    drive('0, '0);
    chk("t6_keep_to0", to0, 4'b0011);
    chk("t6_keep_ws0", ws0, 12'h001);
    chk("t6_rst_cp1", cp1, 4'b0000);
    tick();
    reset = 1'b0;
    drive('0, cb(0, 0));
    chk("t6_ws0", ws0, 12'h000);
    chk("t6_ws1", ws1, 12'h000);
    chk("t6_post_to0", to0, 4'b0000);
    chk("t6_post_to1", to1, 4'b0000);
    chk("t6_tw0", tw0, 4'b0000);
    chk("t6_tw1", tw1, 4'b0000);
    chk("t6_post_cp0", cp0, 4'b0000);
    tick();
    drive('0, '0); chk("t6_post_cp1", cp1, 4'b0000); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
